// File: rtl/fft_ram_wr.sv
// fft_ram_wr: captures one aligned FFT output frame per enable window,
// converts each complex bin to squared magnitude and writes the lower
// WR_POINTS bins into the spectrum RAM, then raises fft_shutdown.
//
// Beat handshake: a beat is transferred on a rising edge where fft_tvalid=1
// and the engine is in SYNC or WRITE with fft_valid=1. There is no ready
// back-pressure; the engine consumes every qualified beat, and beats seen in
// IDLE or DONE are ignored. fft_tlast is meaningful only together with
// fft_tvalid.
module fft_ram_wr #(
    parameter int POINTS    = 1024,
    parameter int WR_POINTS = 512,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fft_valid,
    input  logic [31:0]       fft_tdata,
    input  logic              fft_tvalid,
    input  logic              fft_tlast,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [31:0]       ram_wr_data,
    output logic              fft_shutdown,
    output logic              frame_err
);

    localparam int CNT_W = (POINTS > 1) ? $clog2(POINTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last_bin;
    logic               err_set;
    logic               abort;
    logic               beat_wr;

    // Magnitude pipeline registers.
    logic               s1_vld;
    logic signed [15:0] s1_re;
    logic signed [15:0] s1_im;
    logic [ADDR_W-1:0]  s1_idx;
    logic               s2_vld;
    logic [31:0]        s2_re2;
    logic [31:0]        s2_im2;
    logic [ADDR_W-1:0]  s2_idx;

    logic signed [31:0] re_ext;
    logic signed [31:0] im_ext;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;

    assign last_bin     = (cnt == CNT_W'(POINTS - 1));
    assign fft_shutdown = (state == DONE);

    // Next-state, bin counter and write-issue decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_set   = 1'b0;
        abort     = 1'b0;
        beat_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (fft_valid) state_nxt = SYNC;
            end
            SYNC: begin
                if (!fft_valid) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (fft_tvalid && fft_tlast) begin
                    state_nxt = WRITE;
                    cnt_nxt   = '0;
                end
            end
            WRITE: begin
                // Enable dropping wins over any beat on the same edge.
                if (!fft_valid) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (fft_tvalid) begin
                    beat_wr = (int'(cnt) < WR_POINTS);
                    if (last_bin && fft_tlast) begin
                        state_nxt = DONE;
                    end else if (last_bin || fft_tlast) begin
                        // Length mismatch: this beat closes the bad frame.
                        err_set   = 1'b1;
                        state_nxt = SYNC;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!fft_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (err_set) frame_err <= 1'b1;
        end
    end

    // Squares of the stage-1 operands; each fits in 32 bits (max 2^30).
    always_comb begin
        re_ext = 32'(s1_re);
        im_ext = 32'(s1_im);
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
    end

    // Three-stage magnitude pipeline; an abort clears every valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld      <= 1'b0;
            s1_re       <= '0;
            s1_im       <= '0;
            s1_idx      <= '0;
            s2_vld      <= 1'b0;
            s2_re2      <= '0;
            s2_im2      <= '0;
            s2_idx      <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            s1_vld    <= beat_wr;
            s1_re     <= fft_tdata[15:0];
            s1_im     <= fft_tdata[31:16];
            s1_idx    <= ADDR_W'(cnt);
            s2_vld    <= s1_vld && !abort;
            s2_re2    <= re_sq;
            s2_im2    <= im_sq;
            s2_idx    <= s1_idx;
            ram_wr_en <= s2_vld && !abort;
            if (s2_vld) begin
                ram_wr_addr <= s2_idx;
                ram_wr_data <= s2_re2 + s2_im2;
            end
        end
    end

endmodule
